adder_result_accumulator: RTL and testbench
===========================================

ADDER_RESULT_ACCUMULATOR -- requirements
Module: adder_result_accumulator

Interface
REQ-001 Parameter: CNT_W, 4, width of the count input; a burst holds 1..2^CNT_W results.
REQ-002 Parameter: TOT_W, 16, accumulator/output width; SHALL be >= 9+CNT_W.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin a burst; sampled only in IDLE or HOLD-with-handshake.
REQ-006 count  in  CNT_W  results per burst, sampled with start; 0 means 2^CNT_W.
REQ-007 in_valid  in  1  one adder result present this cycle; the upstream pipelined 8-bit adder cannot stall.
REQ-008 in_sum  in  8  adder sum bits.
REQ-009 in_cout  in  1  adder carry-out.
REQ-010 in_ready  out  1  high only in ACC; a result is accepted when in_valid && in_ready.
REQ-011 out_valid  out  1  burst total available.
REQ-012 out_ready  in  1  consumer takes the total when out_valid && out_ready.
REQ-013 out_total  out  TOT_W  sum of accepted 9-bit results {in_cout,in_sum}.
REQ-014 busy  out  1  high in ACC or HOLD.
REQ-015 dropped  out  1  sticky: a result arrived while in_ready was low.

Function
REQ-016 FSM states IDLE, ACC, HOLD; encoding unconstrained.
REQ-017 IDLE: start=1 -> load remaining=count (0 -> 2^CNT_W), clear accumulator, clear dropped, go ACC next cycle.
REQ-018 ACC: each accepted result adds zero-extended {in_cout,in_sum} to the accumulator and decrements remaining.
REQ-019 ACC: acceptance with remaining==1 -> go HOLD; out_valid rises the cycle after the last accepted result (1-cycle latency).
REQ-020 ACC: start ignored; count not re-sampled.
REQ-021 HOLD: out_valid=1, out_total and in_ready=0 held stable until handshake.
REQ-022 HOLD + out_ready=1 + start=0 -> IDLE next cycle, out_valid low.
REQ-023 HOLD + out_ready=1 + start=1 -> ACC next cycle, new count loaded, accumulator cleared, dropped cleared; no idle bubble.
REQ-024 HOLD + out_ready=0 + start=1 -> start ignored.
REQ-025 in_valid=1 while in_ready=0 (IDLE or HOLD) -> result discarded, dropped set next cycle; accumulator unchanged.
REQ-026 Accumulator arithmetic unsigned; width rule in REQ-002 guarantees no wrap (max 2^CNT_W x 511).
REQ-027 out_total SHALL read 0 in IDLE after reset and hold the last total after IDLE entry via handshake until the next start.

Reset
REQ-028 rst low -> immediately IDLE, remaining=0, accumulator=0, out_valid=0, in_ready=0, busy=0, dropped=0, regardless of state or handshake in progress.
REQ-029 Reset mid-burst SHALL discard partial accumulation; first start after release begins a fresh burst.
REQ-030 Deassertion of rst SHALL be honoured on a clock edge; outputs stay at reset values until the first edge after release.

Structure
REQ-031 Shared package holds FSM state encodings and default CNT_W/TOT_W constants.
REQ-032 Single module; no sub-module required; accumulator and down-counter are inline registers.

Verification
REQ-033 start, count=5; results 2, 41, 151, 256 ({1,0x00}), 400 ({1,0x90}) on consecutive cycles -> out_valid the cycle after the 5th, out_total=850.
REQ-034 count=0; 16 results of {1,0xFF} -> out_total=8176, no wrap.
REQ-035 HOLD with out_ready=0 for 3 cycles while in_valid=1 -> out_total stable, dropped=1; next start clears dropped.
REQ-036 HOLD, out_ready=1 and start=1, count=1, same cycle -> ACC next cycle; next result 41 -> out_total=41.
REQ-037 rst low after 2 of 4 results accepted -> all outputs 0 immediately; new burst count=1, result 2 -> out_total=2.

Source files
------------

// File: rtl/adder_result_accumulator_pkg.sv
// Shared constants and FSM encodings for the adder result accumulator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adder_result_accumulator_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_TOT_W = 16;

    // Width of a single adder result: carry-out plus 8 sum bits.
    localparam int RES_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/adder_result_accumulator.sv
// Sums a burst of 1..2^CNT_W 9-bit adder results and presents the total.
// Latency: out_valid rises the cycle after the last accepted result.
// Backpressure: total held until out_ready; results arriving outside ACC are dropped (sticky flag).
module adder_result_accumulator
    import adder_result_accumulator_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TOT_W = DEF_TOT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    input  logic [7:0]       in_sum,
    input  logic             in_cout,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOT_W-1:0] out_total,
    output logic             busy,
    output logic             dropped
);

    state_t           state, state_n;
    logic [CNT_W:0]   remaining, remaining_n;
    logic [TOT_W-1:0] acc, acc_n;
    logic             dropped_q, dropped_n;

    logic             accept;
    logic             load;
    logic [CNT_W:0]   load_val;
    logic [TOT_W-1:0] result_ext;

    // A count of zero encodes a full burst of 2^CNT_W results.
    assign load_val   = (count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count};
    assign result_ext = {{(TOT_W-RES_W){1'b0}}, in_cout, in_sum};

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign out_total = acc;
    assign dropped   = dropped_q;

    assign accept = in_valid && in_ready;
    // New burst starts from IDLE, or straight from HOLD when the total is taken in the same cycle.
    assign load   = start && ((state == ST_IDLE) || ((state == ST_HOLD) && out_ready));

    // State, counter, accumulator and drop flag registers; reset forces a clean IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc       <= '0;
            dropped_q <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            acc       <= acc_n;
            dropped_q <= dropped_n;
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        acc_n       = acc;
        dropped_n   = dropped_q;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_ACC;
                end
            end
            ST_ACC: begin
                if (accept && (remaining == {{CNT_W{1'b0}}, 1'b1})) begin
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_n = start ? ST_ACC : ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            remaining_n = load_val;
            acc_n       = '0;
            dropped_n   = 1'b0;
        end

        if (accept) begin
            acc_n       = acc + result_ext;
            remaining_n = remaining - {{CNT_W{1'b0}}, 1'b1};
        end

        // The upstream adder cannot stall, so anything offered outside ACC is lost; remember it.
        if (in_valid && !in_ready) begin
            dropped_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench for adder_result_accumulator with directed bursts.
// Latency: checks out_valid one cycle after the last result.
// Backpressure: exercises HOLD stalls, back-to-back restart and drops.
module tb_adder_result_accumulator;

    localparam int CNT_W = 4;
    localparam int TOT_W = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             in_valid;
    logic [7:0]       in_sum;
    logic             in_cout;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [TOT_W-1:0] out_total;
    logic             busy;
    logic             dropped;

    int checks = 0;
    int errors = 0;
    logic [TOT_W-1:0] exp_q[$];

    adder_result_accumulator #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_total (out_total),
        .busy      (busy),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every output handshake is compared against the oldest expected total.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_total: got %0d expected none", out_total);
            end else begin
                logic [TOT_W-1:0] e;
                e = exp_q.pop_front();
                if (out_total !== e) begin
                    errors++;
                    $display("FAIL total: got %0d expected %0d", out_total, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [8:0] r);
        in_valid = 1'b1;
        {in_cout, in_sum} = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic begin_burst(input logic [CNT_W-1:0] c);
        start = 1'b1;
        count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic take_total();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        count = '0;
        in_valid = 1'b0;
        in_sum = '0;
        in_cout = 1'b0;
        out_ready = 1'b0;

        #3;
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_in_ready", 32'(in_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_dropped", 32'(dropped), 0);
        chk("reset_total", 32'(out_total), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_after_release_busy", 32'(busy), 0);

        // Five mixed results including carry-out set.
        begin_burst(4'd5);
        chk("acc_in_ready", 32'(in_ready), 1);
        chk("acc_busy", 32'(busy), 1);
        exp_q.push_back(16'd850);
        send(9'd2);
        send(9'd41);
        send(9'd151);
        send({1'b1, 8'h00});
        chk("not_done_early", 32'(out_valid), 0);
        send({1'b1, 8'h90});
        chk("valid_latency", 32'(out_valid), 1);
        chk("hold_in_ready", 32'(in_ready), 0);
        take_total();
        chk("idle_after_take", 32'(out_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_total_held", 32'(out_total), 850);

        // A result offered in IDLE is dropped and does not touch the total.
        send(9'd77);
        chk("idle_drop_flag", 32'(dropped), 1);
        chk("idle_drop_total", 32'(out_total), 850);

        // Full-length burst of maximum results.
        begin_burst(4'd0);
        chk("start_clears_drop", 32'(dropped), 0);
        chk("start_clears_acc", 32'(out_total), 0);
        exp_q.push_back(16'd8176);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("full_not_done_early", 32'(out_valid), 0);
            send(9'h1FF);
        end
        chk("full_valid", 32'(out_valid), 1);
        take_total();

        // Stalled HOLD with incoming results and an ignored start.
        begin_burst(4'd2);
        exp_q.push_back(16'd3);
        send(9'd1);
        send(9'd2);
        in_valid = 1'b1;
        {in_cout, in_sum} = 9'h0AA;
        start = 1'b1;
        count = 4'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_total_stable", 32'(out_total), 3);
            chk("hold_valid_stable", 32'(out_valid), 1);
        end
        in_valid = 1'b0;
        chk("hold_dropped", 32'(dropped), 1);
        chk("hold_no_ready", 32'(in_ready), 0);

        // Handshake and restart in the same cycle.
        count = 4'd1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        out_ready = 1'b0;
        chk("restart_in_acc", 32'(in_ready), 1);
        chk("restart_valid_low", 32'(out_valid), 0);
        chk("restart_drop_clear", 32'(dropped), 0);
        exp_q.push_back(16'd41);
        send(9'd41);
        chk("restart_valid", 32'(out_valid), 1);
        take_total();

        // Reset mid-burst discards the partial sum.
        begin_burst(4'd4);
        send(9'd10);
        send(9'd20);
        chk("partial_total", 32'(out_total), 30);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 0);
        chk("midreset_in_ready", 32'(in_ready), 0);
        chk("midreset_total", 32'(out_total), 0);
        chk("midreset_valid", 32'(out_valid), 0);
        tick();
        rst = 1'b1;
        tick();
        begin_burst(4'd1);
        exp_q.push_back(16'd2);
        send(9'd2);
        chk("post_reset_valid", 32'(out_valid), 1);
        take_total();

        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
